icache_fetch_responder: RTL and testbench
=========================================

# icache_fetch_responder

Cache-side responder for the instruction-fetch request/response handshake; it answers the fetcher's `toCache_req`/`toCache_pc` with `fromCache_resp`/`fromCache_instr`. Holds a direct-mapped, one-word-per-line instruction cache. Misses are refilled through a simple req/ack memory port. It sits between the ifetcher and the instruction memory/bus.

## Interface
- `LINES`, 16, number of cache lines; power of two, ≥2; `IDXW = log2(LINES)`
- `PCW`, 32, PC/address width
- `IW`, 32, instruction width
- `iClk` input 1: clock; all logic is on the rising edge.
- `iResetn` input 1: reset, synchronous, active-low.
- `fromFetcher_req` input 1: fetch request, level; held by the fetcher until the response.
- `fromFetcher_pc` input PCW: fetch address, sampled at acceptance.
- `toFetcher_resp` output 1: response valid, one-cycle pulse.
- `toFetcher_instr` output IW: instruction, valid while `toFetcher_resp`=1.
- `toMem_req` output 1: refill request, held until ack.
- `toMem_addr` output PCW: refill address, word-aligned.
- `fromMem_ack` input 1: refill done; `fromMem_rdata` is valid in the same cycle.
- `fromMem_rdata` input IW: refill data.
- `iInvalidate` input 1: invalidate all lines (fence.i).
- `oBusy` output 1: high when state ≠ IDLE.

## Operation
- Address split:
  - `pc[1:0]` is ignored.
  - index = `pc[IDXW+1:2]`.
  - tag = `pc[PCW-1:IDXW+2]`.
- Storage per line: valid bit, tag, and IW data.
- State machine, encoded in 2 bits:
  - **IDLE**: when `fromFetcher_req`=1, register the pc and go to LOOKUP. Otherwise stay.
  - **LOOKUP**: read the indexed line.
    - Hit (valid and tag match, with `iInvalidate`=0 this cycle): load the data into the output register and go to RESP.
    - Otherwise go to MREQ.
  - **MREQ**:
    - Drive `toMem_req`=1 and `toMem_addr` = {pc[PCW-1:2], 2'b00}.
    - On `fromMem_ack`=1: write the line (valid=1, tag, data), load `fromMem_rdata` into the output register, and go to RESP.
  - **RESP**: `toFetcher_resp`=1 for this cycle only, then go to IDLE.
- A request still high in IDLE the cycle after RESP is a new request. Back-to-back fetches therefore occur naturally.
- `fromFetcher_req` and pc changes outside IDLE are ignored; the pc registered at acceptance is used.
- `fromMem_ack` outside MREQ is ignored.
- `iInvalidate`:
  - It clears all valid bits at the next edge, in any state.
  - A LOOKUP in the same cycle is forced to miss.
  - If it is asserted in MREQ on or before the ack cycle, the refill still responds to the fetcher, but the written line is left invalid.
  - Invalidate has priority over the fill's valid set.
- Reset (`iResetn`=0 at an edge), including mid-miss:
  - state goes to IDLE and all valid bits clear;
  - `toMem_req`, `toFetcher_resp` and `oBusy` are 0, `toFetcher_instr` and `toMem_addr` are 0;
  - a late `fromMem_ack` after reset is ignored.
- Tag and data arrays need no reset; only the valid bits are reset.

## Timing
- Request sampled at edge E0 (state IDLE → LOOKUP).
- Hit: `toFetcher_resp`=1 in the cycle after E0+1, i.e. 2 cycles after acceptance.
- Miss:
  - `toMem_req` rises in the cycle after edge E0+1.
  - If `fromMem_ack` arrives k cycles after `toMem_req` rises (k=0 means same cycle), resp is at acceptance + 3 + k.
- `toMem_req` and `toMem_addr` are registered outputs, stable from rise until the ack cycle inclusive. `toMem_req`=0 the cycle after ack.
- `toFetcher_instr` holds its value after RESP until the next load. Only the cycle with resp=1 is meaningful.
- `oBusy` = 1 from the cycle after acceptance through RESP inclusive.

## Test plan
- Reset, then pc=0x100 req held, memory acks 2 cycles after `toMem_req` with 0xDEAD0001 → `toMem_addr`=0x100, resp at acceptance+5 with instr 0xDEAD0001; line 0 is filled.
- Repeat pc=0x102 (same word) → no `toMem_req`, resp at acceptance+2 with 0xDEAD0001.
- With LINES=16: pc=0x100 then pc=0x140 (same index, different tag), then 0x100 again → three misses, the third refetches from memory.
- Hit pc=0x100 warm, pulse `iInvalidate` during MREQ of pc=0x104 → 0x104 responds with mem data; subsequent 0x100 and 0x104 both miss.
- Assert `iResetn`=0 in MREQ for 1 cycle, then ack → `toMem_req`=0 after reset, ack ignored, no resp, `oBusy`=0; next req performs a fresh miss.
- `fromFetcher_req` held continuously on a hitting pc → resp every 3 cycles (IDLE, LOOKUP, RESP), instr correct each time.

Source files
------------

// File: rtl/icache_fetch_responder.sv
// -----------------------------------------------------------------------------
// icache_fetch_responder
//
// Cache-side responder for the instruction-fetch handshake. It holds a
// direct-mapped, one-word-per-line instruction cache and answers each fetch
// request from the fetcher with a one-cycle response pulse. Misses are refilled
// through a simple req/ack memory port.
//
// Ports:
//   iClk             in   clock, rising edge
//   iResetn          in   synchronous active-low reset
//   fromFetcher_req  in   fetch request (level, held until response)
//   fromFetcher_pc   in   fetch address, sampled when the request is accepted
//   toFetcher_resp   out  response valid, one-cycle pulse
//   toFetcher_instr  out  instruction, meaningful while toFetcher_resp=1
//   toMem_req        out  refill request, held until fromMem_ack
//   toMem_addr       out  refill address (word aligned)
//   fromMem_ack      in   refill done, fromMem_rdata valid in the same cycle
//   fromMem_rdata    in   refill data
//   iInvalidate      in   invalidate all lines (fence.i)
//   oBusy            out  high whenever the state machine is not idle
// -----------------------------------------------------------------------------
module icache_fetch_responder #(
  parameter int LINES = 16,
  parameter int PCW   = 32,
  parameter int IW    = 32
) (
  input  logic             iClk,
  input  logic             iResetn,
  input  logic             fromFetcher_req,
  input  logic [PCW-1:0]   fromFetcher_pc,
  output logic             toFetcher_resp,
  output logic [IW-1:0]    toFetcher_instr,
  output logic             toMem_req,
  output logic [PCW-1:0]   toMem_addr,
  input  logic             fromMem_ack,
  input  logic [IW-1:0]    fromMem_rdata,
  input  logic             iInvalidate,
  output logic             oBusy
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = PCW - IDXW - 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_MREQ   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_next;
  logic [PCW-1:0]   r_pc;
  logic [PCW-1:0]   w_pc_next;
  logic [IW-1:0]    r_instr;
  logic [IW-1:0]    w_instr_next;
  logic             r_mem_req;
  logic             w_mem_req_next;
  logic [PCW-1:0]   r_mem_addr;
  logic [PCW-1:0]   w_mem_addr_next;
  // Remembers an invalidate seen during the current refill so the line being
  // filled is not marked valid with data that may predate the fence.
  logic             r_inv_pend;
  logic             w_inv_pend_next;

  // ---------------------------------------------------------------------------
  // Cache storage: valid bits in flops (they need reset and a bulk clear),
  // tag and data in plain arrays with a registered read port.
  // ---------------------------------------------------------------------------
  logic [LINES-1:0] r_valid;
  logic [TAGW-1:0]  r_tag_mem  [LINES];
  logic [IW-1:0]    r_data_mem [LINES];
  logic [TAGW-1:0]  r_rd_tag;
  logic [IW-1:0]    r_rd_data;

  logic [IDXW-1:0]  w_req_idx;
  logic [IDXW-1:0]  w_idx;
  logic [TAGW-1:0]  w_tag;
  logic             w_hit;
  logic             w_fill;
  logic             w_fill_valid;

  // The read address comes from the incoming pc so the read data is ready in
  // LOOKUP, one edge after acceptance.
  assign w_req_idx = fromFetcher_pc[IDXW+1:2];
  assign w_idx     = r_pc[IDXW+1:2];
  assign w_tag     = r_pc[PCW-1:IDXW+2];

  // An invalidate arriving in the LOOKUP cycle forces a miss.
  assign w_hit = (r_state == S_LOOKUP) && r_valid[w_idx] &&
                 (r_rd_tag == w_tag) && !iInvalidate;

  assign w_fill       = (r_state == S_MREQ) && fromMem_ack;
  assign w_fill_valid = w_fill && !iInvalidate && !r_inv_pend;

  // ---------------------------------------------------------------------------
  // Tag/data arrays: write on refill, registered read every cycle.
  // Reads are only consumed in LOOKUP and no write can happen on the edge
  // that enters LOOKUP, so read-during-write ordering never matters.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (w_fill) begin
      r_tag_mem[w_idx]  <= w_tag;
      r_data_mem[w_idx] <= fromMem_rdata;
    end
    r_rd_tag  <= r_tag_mem[w_req_idx];
    r_rd_data <= r_data_mem[w_req_idx];
  end

  // ---------------------------------------------------------------------------
  // Valid bits: invalidate beats a same-cycle fill of the line.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge iClk) begin
        if (!iResetn) begin
          r_valid[gi] <= 1'b0;
        end else if (iInvalidate) begin
          r_valid[gi] <= 1'b0;
        end else if (w_fill_valid && (w_idx == IDXW'(gi))) begin
          r_valid[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: state register plus registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (!iResetn) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_instr    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_inv_pend <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_instr    <= w_instr_next;
      r_mem_req  <= w_mem_req_next;
      r_mem_addr <= w_mem_addr_next;
      r_inv_pend <= w_inv_pend_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_instr_next    = r_instr;
    w_mem_req_next  = r_mem_req;
    w_mem_addr_next = r_mem_addr;
    w_inv_pend_next = r_inv_pend;

    case (r_state)
      S_IDLE: begin
        if (fromFetcher_req) begin
          w_pc_next    = fromFetcher_pc;
          w_state_next = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        w_inv_pend_next = 1'b0;
        if (w_hit) begin
          w_instr_next = r_rd_data;
          w_state_next = S_RESP;
        end else begin
          // Request and address are registered here so they are stable
          // from the first MREQ cycle through the ack cycle.
          w_mem_req_next  = 1'b1;
          w_mem_addr_next = {r_pc[PCW-1:2], 2'b00};
          w_state_next    = S_MREQ;
        end
      end

      S_MREQ: begin
        if (iInvalidate) begin
          w_inv_pend_next = 1'b1;
        end
        if (fromMem_ack) begin
          w_instr_next   = fromMem_rdata;
          w_mem_req_next = 1'b0;
          w_state_next   = S_RESP;
        end
      end

      S_RESP: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign toFetcher_resp  = (r_state == S_RESP);
  assign toFetcher_instr = r_instr;
  assign toMem_req       = r_mem_req;
  assign toMem_addr      = r_mem_addr;
  assign oBusy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_icache_fetch_responder.sv
// -----------------------------------------------------------------------------
// tb_icache_fetch_responder
//
// Directed bench for icache_fetch_responder with LINES=16. A small memory
// model acks refill requests after a programmable delay; each fetch is
// checked for miss/hit behaviour, refill address, response latency and
// returned instruction.
// -----------------------------------------------------------------------------
module tb_icache_fetch_responder;

  logic        clk;
  logic        rstn;
  logic        req;
  logic [31:0] pc;
  logic        resp;
  logic [31:0] instr;
  logic        mreq;
  logic [31:0] maddr;
  logic        ack;
  logic [31:0] rdata;
  logic        inv;
  logic        busy;

  int n_checks;
  int n_fail;

  icache_fetch_responder #(
    .LINES(16),
    .PCW  (32),
    .IW   (32)
  ) dut (
    .iClk           (clk),
    .iResetn        (rstn),
    .fromFetcher_req(req),
    .fromFetcher_pc (pc),
    .toFetcher_resp (resp),
    .toFetcher_instr(instr),
    .toMem_req      (mreq),
    .toMem_addr     (maddr),
    .fromMem_ack    (ack),
    .fromMem_rdata  (rdata),
    .iInvalidate    (inv),
    .oBusy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // One fetch transaction. Called at a negedge with the DUT idle. The pc bus
  // is scrambled after acceptance to show the registered pc is used.
  // inv_at: refill cycle (0 = first toMem_req cycle) to pulse iInvalidate, -1 none.
  task automatic do_fetch(input string name, input logic [31:0] fpc,
                          input logic [31:0] mdata, input int ack_dly,
                          input int inv_at, input bit exp_miss,
                          input int exp_lat, input logic [31:0] exp_instr);
    int  cnt;
    int  mcnt;
    int  lat;
    bit  seen;
    bit  done;
    req  = 1'b1;
    pc   = fpc;
    cnt  = 0;
    mcnt = 0;
    lat  = -1;
    seen = 1'b0;
    done = 1'b0;
    while (!done && cnt < 40) begin
      @(negedge clk);
      cnt++;
      ack = 1'b0;
      inv = 1'b0;
      if (cnt == 1) pc = ~fpc;
      if (mreq) begin
        if (!seen) check_eq({name, "_addr"}, maddr, fpc & 32'hFFFF_FFFC);
        seen = 1'b1;
        if (mcnt == inv_at) inv = 1'b1;
        if (mcnt == ack_dly) begin
          ack   = 1'b1;
          rdata = mdata;
        end
        mcnt++;
      end
      if (resp) begin
        done = 1'b1;
        lat  = cnt;
        check_eq({name, "_instr"}, instr, exp_instr);
        check_eq({name, "_mreq_at_resp"}, {31'd0, mreq}, 32'd0);
        check_eq({name, "_busy_at_resp"}, {31'd0, busy}, 32'd1);
      end
    end
    req = 1'b0;
    ack = 1'b0;
    inv = 1'b0;
    check_eq({name, "_done"}, {31'd0, done}, 32'd1);
    check_eq({name, "_miss"}, {31'd0, seen}, {31'd0, exp_miss});
    check_eq({name, "_lat"}, lat, exp_lat);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn  = 1'b0;
    req   = 1'b0;
    pc    = '0;
    ack   = 1'b0;
    rdata = '0;
    inv   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_resp",  {31'd0, resp}, 32'd0);
    check_eq("rst_mreq",  {31'd0, mreq}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy}, 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_maddr", maddr, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Cold miss, ack 2 cycles after toMem_req: resp at acceptance+5
    do_fetch("miss100", 32'h100, 32'hDEAD_0001, 2, -1, 1'b1, 5, 32'hDEAD_0001);
    // Same word, different byte offset: hit in 2
    do_fetch("hit102", 32'h102, 32'h0, 0, -1, 1'b0, 2, 32'hDEAD_0001);
    // Conflict on index 0: 0x140 evicts 0x100, then 0x100 refetches
    do_fetch("miss140", 32'h140, 32'hCAFE_0140, 1, -1, 1'b1, 4, 32'hCAFE_0140);
    do_fetch("hit140", 32'h140, 32'h0, 0, -1, 1'b0, 2, 32'hCAFE_0140);
    do_fetch("remiss100", 32'h100, 32'hDEAD_0002, 0, -1, 1'b1, 3, 32'hDEAD_0002);
    do_fetch("warm100", 32'h100, 32'h0, 0, -1, 1'b0, 2, 32'hDEAD_0002);
    // Invalidate during the refill of 0x104: still answers, line not kept
    do_fetch("inv104", 32'h104, 32'hBEEF_0104, 1, 0, 1'b1, 4, 32'hBEEF_0104);
    do_fetch("post_inv100", 32'h100, 32'h1111_0100, 0, -1, 1'b1, 3, 32'h1111_0100);
    do_fetch("post_inv104", 32'h104, 32'h2222_0104, 0, -1, 1'b1, 3, 32'h2222_0104);
    // Invalidate on the ack cycle itself also leaves the line invalid
    do_fetch("inv_ack108", 32'h108, 32'h3333_0108, 1, 1, 1'b1, 4, 32'h3333_0108);
    do_fetch("re108", 32'h108, 32'h4444_0108, 0, -1, 1'b1, 3, 32'h4444_0108);

    // Reset in the middle of a refill; a late ack is ignored
    req = 1'b1;
    pc  = 32'h200;
    begin
      int w;
      w = 0;
      while (!mreq && w < 20) begin
        @(negedge clk);
        w++;
      end
      check_eq("rstmiss_mreq_seen", {31'd0, mreq}, 32'd1);
    end
    rstn = 1'b0;
    req  = 1'b0;
    @(negedge clk);
    rstn  = 1'b1;
    ack   = 1'b1;
    rdata = 32'h5555_5555;
    check_eq("rstmiss_mreq",  {31'd0, mreq}, 32'd0);
    check_eq("rstmiss_busy",  {31'd0, busy}, 32'd0);
    check_eq("rstmiss_instr", instr, 32'd0);
    check_eq("rstmiss_maddr", maddr, 32'd0);
    @(negedge clk);
    ack = 1'b0;
    check_eq("rstmiss_resp", {31'd0, resp}, 32'd0);
    check_eq("rstmiss_busy2", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_eq("rstmiss_resp2", {31'd0, resp}, 32'd0);
    // Fresh miss after reset; earlier lines were also wiped
    do_fetch("fresh200", 32'h200, 32'h6666_0200, 0, -1, 1'b1, 3, 32'h6666_0200);
    do_fetch("rst_wiped108", 32'h108, 32'h7777_0108, 0, -1, 1'b1, 3, 32'h7777_0108);

    // Request held on a hitting pc: resp every 3 cycles
    req = 1'b1;
    pc  = 32'h200;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (mreq) ack = 1'b1; // only reached if the DUT wrongly misses
      check_eq($sformatf("b2b_resp_c%0d", c), {31'd0, resp}, ((c % 3) == 2) ? 32'd1 : 32'd0);
      if ((c % 3) == 2) check_eq($sformatf("b2b_instr_c%0d", c), instr, 32'h6666_0200);
    end
    req = 1'b0;
    ack = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("final_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
